// File: rtl/sprite_draw_scheduler.sv
// Per-frame sprite sequencer: erase every slot at its old position, request one move step,
// then redraw every visible slot. Define SPRITE_SCHED_CLIP_EN to clip plots to a 160x120 screen.
module sprite_draw_scheduler #(
  parameter int SLOTS = 10,
  parameter int SPR_W = 4,
  parameter int SPR_H = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             frame_tick,
  input  logic [SLOTS-1:0] vis_mask,
  output logic [3:0]       slot,
  input  logic [7:0]       slot_x,
  input  logic [7:0]       slot_y,
  output logic             move_req,
  output logic             plot,
  output logic [7:0]       plot_x,
  output logic [6:0]       plot_y,
  output logic [2:0]       colour,
  output logic             busy,
  output logic             frame_done,
  output logic             overrun
);

  localparam int NPIX  = SPR_W * SPR_H;
  localparam int PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;

  typedef enum logic [2:0] {
    IDLE, ERASE_SETUP, ERASE, MOVE, DRAW_SETUP, DRAW, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       slot_q, slot_d;
  logic [PIX_W-1:0] pix_q, pix_d;

  // Old-position buffer: what was drawn last frame, so it can be erased this frame.
  logic             old_vis [SLOTS];
  logic [7:0]       old_x   [SLOTS];
  logic [7:0]       old_y   [SLOTS];

  logic             last_slot, last_pix, drawing, in_view;
  logic [7:0]       base_x, base_y, dx, dy, pix_x;
  logic [6:0]       pix_y;
  logic [2:0]       pix_colour;
  logic [7:0]       hold_x;
  logic [6:0]       hold_y;
  logic [2:0]       hold_c;

  assign last_slot = (slot_q == 4'(SLOTS - 1));
  assign last_pix  = (pix_q == PIX_W'(NPIX - 1));

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    pix_d   = pix_q;
    unique case (state_q)
      IDLE: begin
        if (frame_tick) begin
          state_d = ERASE_SETUP;
          slot_d  = '0;
        end
      end
      ERASE_SETUP: begin
        if (old_vis[slot_q]) begin
          state_d = ERASE;
          pix_d   = '0;
        end else if (last_slot) begin
          state_d = MOVE;
        end else begin
          slot_d = slot_q + 4'd1;
        end
      end
      ERASE: begin
        pix_d = last_pix ? '0 : pix_q + 1'b1;
        if (last_pix) begin
          if (last_slot) begin
            state_d = MOVE;
          end else begin
            state_d = ERASE_SETUP;
            slot_d  = slot_q + 4'd1;
          end
        end
      end
      MOVE: begin
        state_d = DRAW_SETUP;
        slot_d  = '0;
      end
      DRAW_SETUP: begin
        if (vis_mask[slot_q]) begin
          state_d = DRAW;
          pix_d   = '0;
        end else if (last_slot) begin
          state_d = DONE;
        end else begin
          slot_d = slot_q + 4'd1;
        end
      end
      DRAW: begin
        pix_d = last_pix ? '0 : pix_q + 1'b1;
        if (last_pix) begin
          if (last_slot) begin
            state_d = DONE;
          end else begin
            state_d = DRAW_SETUP;
            slot_d  = slot_q + 4'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // DRAW reads the entry written in its own DRAW_SETUP, so both passes share one address path.
  assign base_x     = old_x[slot_q];
  assign base_y     = old_y[slot_q];
  assign dx         = 8'(int'(pix_q) % SPR_W);
  assign dy         = 8'(int'(pix_q) / SPR_W);
  assign drawing    = (state_q == ERASE) || (state_q == DRAW);
  assign pix_colour = (state_q == DRAW) ? 3'b111 : 3'b000;

`ifdef SPRITE_SCHED_CLIP_EN
  logic [8:0] ux, uy;
  assign ux      = {1'b0, base_x} + {1'b0, dx};
  assign uy      = {1'b0, base_y} + {1'b0, dy};
  assign in_view = (ux < 9'd160) && (uy < 9'd120);
  assign pix_x   = ux[7:0];
  assign pix_y   = uy[6:0];
`else
  assign in_view = 1'b1;
  assign pix_x   = base_x + dx;
  assign pix_y   = 7'(base_y + dy);
`endif

  assign plot       = drawing && in_view;
  assign plot_x     = plot ? pix_x : hold_x;
  assign plot_y     = plot ? pix_y : hold_y;
  assign colour     = plot ? pix_colour : hold_c;
  assign slot       = slot_q;
  assign busy       = (state_q != IDLE);
  assign move_req   = (state_q == MOVE);
  assign frame_done = (state_q == DONE);
  assign overrun    = frame_tick && busy;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      slot_q  <= '0;
      pix_q   <= '0;
      hold_x  <= '0;
      hold_y  <= '0;
      hold_c  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      pix_q   <= pix_d;
      if (plot) begin
        hold_x <= pix_x;
        hold_y <= pix_y;
        hold_c <= pix_colour;
      end
    end
  end

  // NOTE: this buffer is reset on purpose so the first frame after reset erases nothing;
  // it must stay in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SLOTS; i++) begin
        old_vis[i] <= 1'b0;
        old_x[i]   <= '0;
        old_y[i]   <= '0;
      end
    end else if (state_q == DRAW_SETUP) begin
      old_vis[slot_q] <= vis_mask[slot_q];
      old_x[slot_q]   <= slot_x;
      old_y[slot_q]   <= slot_y;
    end
  end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Self-checking bench for sprite_draw_scheduler: a per-frame expected-cycle list is built from
// the sequencing rules and compared against the DUT every cycle; directed literals pin the model.
module tb_sprite_draw_scheduler;

  localparam int SLOTS = 10;
  localparam int SPR_W = 4;
  localparam int SPR_H = 4;
  localparam int NPIX  = SPR_W * SPR_H;
`ifdef SPRITE_SCHED_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             frame_tick = 1'b0;
  logic [SLOTS-1:0] vis_mask = '0;
  logic [3:0]       slot;
  logic [7:0]       slot_x, slot_y;
  logic             move_req, plot;
  logic [7:0]       plot_x;
  logic [6:0]       plot_y;
  logic [2:0]       colour;
  logic             busy, frame_done, overrun;

  always #5 clk = ~clk;

  sprite_draw_scheduler #(.SLOTS(SLOTS), .SPR_W(SPR_W), .SPR_H(SPR_H)) dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .vis_mask(vis_mask),
    .slot(slot), .slot_x(slot_x), .slot_y(slot_y), .move_req(move_req),
    .plot(plot), .plot_x(plot_x), .plot_y(plot_y), .colour(colour),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Position source: cur_* feeds the DUT, new_* becomes current on move_req.
  logic [7:0] cur_x [SLOTS];
  logic [7:0] cur_y [SLOTS];
  logic [7:0] new_x [SLOTS];
  logic [7:0] new_y [SLOTS];

  always_comb begin
    slot_x = 8'h00;
    slot_y = 8'h00;
    if (int'(slot) < SLOTS) begin
      slot_x = cur_x[slot];
      slot_y = cur_y[slot];
    end
  end

  always @(negedge clk) begin
    if (reset_n && move_req)
      for (int i = 0; i < SLOTS; i++) begin
        cur_x[i] = new_x[i];
        cur_y[i] = new_y[i];
      end
  end

  // ---------------- behavioural model ----------------
  typedef struct {
    bit busy;
    bit setup;
    bit pixel;
    bit move;
    bit done;
    int slot;
    bit plot;
    int x;
    int y;
    int col;
  } rec_t;

  rec_t q[$];
  bit   ob_vis [SLOTS];
  int   ob_x   [SLOTS];
  int   ob_y   [SLOTS];
  int   last_x, last_y, last_c;

  // Frame log of DUT plots, read only against hand-computed literals.
  int wlog[$];
  int white_cnt, blk_cnt;

  task automatic push_sprite(input int s, input int bx, input int by, input int col);
    rec_t r;
    for (int c = 0; c < NPIX; c++) begin
      int ux, uy;
      ux = bx + c % SPR_W;
      uy = by + c / SPR_W;
      r = '{default: 0};
      r.busy = 1; r.pixel = 1; r.slot = s; r.col = col;
      r.x = ux % 256;
      r.y = uy % 128;
      r.plot = CLIP ? (ux < 160 && uy < 120) : 1'b1;
      q.push_back(r);
    end
  endtask

  task automatic build_frame();
    rec_t r;
    for (int s = 0; s < SLOTS; s++) begin
      r = '{default: 0}; r.busy = 1; r.setup = 1; r.slot = s;
      q.push_back(r);
      if (ob_vis[s]) push_sprite(s, ob_x[s], ob_y[s], 0);
    end
    r = '{default: 0}; r.busy = 1; r.move = 1;
    q.push_back(r);
    for (int s = 0; s < SLOTS; s++) begin
      r = '{default: 0}; r.busy = 1; r.setup = 1; r.slot = s;
      q.push_back(r);
      if (vis_mask[s]) push_sprite(s, int'(new_x[s]), int'(new_y[s]), 7);
      ob_vis[s] = vis_mask[s];
      ob_x[s]   = int'(new_x[s]);
      ob_y[s]   = int'(new_y[s]);
    end
    r = '{default: 0}; r.busy = 1; r.done = 1;
    q.push_back(r);
  endtask

  rec_t cr;
  bit   have;

  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      for (int s = 0; s < SLOTS; s++) begin
        ob_vis[s] = 0; ob_x[s] = 0; ob_y[s] = 0;
      end
      last_x = 0; last_y = 0; last_c = 0;
      check("reset_outputs",
            {5'd0, slot, move_req, plot, plot_x, plot_y, colour, busy, frame_done, overrun}, 0);
    end else begin
      have = (q.size() > 0);
      if (have) cr = q.pop_front();
      else      cr = '{default: 0};
      check("busy", busy, cr.busy);
      check("plot", plot, cr.plot);
      check("move_req", move_req, cr.move);
      check("frame_done", frame_done, cr.done);
      check("overrun", overrun, frame_tick && have);
      if (cr.plot) begin
        last_x = cr.x; last_y = cr.y; last_c = cr.col;
      end
      check("plot_x", plot_x, last_x);
      check("plot_y", plot_y, last_y);
      check("colour", colour, last_c);
      if (cr.setup || cr.pixel) check("slot", slot, cr.slot);
      if (plot && colour == 3'b111) begin
        white_cnt++;
        wlog.push_back(int'(plot_x) * 256 + int'(plot_y));
      end
      if (plot && colour == 3'b000) blk_cnt++;
      if (frame_tick && !have) build_frame();
    end
  end

  // ---------------- stimulus ----------------
  int prev_cnt = 0;

  function automatic int frame_len(input int prev, input int cur);
    return 2 * SLOTS + 2 + NPIX * (prev + cur);
  endfunction

  task automatic run_frame(input int extra_at, input int exp_len, input string tag);
    int n;
    bit seen;
    wlog.delete();
    white_cnt = 0;
    blk_cnt   = 0;
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = (extra_at == 1);
    n = 1;
    seen = 0;
    while (n < 2000) begin
      @(negedge clk);
      if (n == extra_at) check({tag, "_overrun_pulse"}, overrun, 1);
      if (frame_done) begin
        seen = 1;
        break;
      end
      @(posedge clk); #1;
      n++;
      frame_tick = (n == extra_at);
    end
    @(posedge clk); #1 frame_tick = 1'b0;
    check({tag, "_done_seen"}, seen, 1);
    if (seen) check({tag, "_len"}, n, exp_len);
    prev_cnt = $countones(vis_mask);
  endtask

  task automatic set_grid();
    for (int s = 0; s < SLOTS; s++) begin
      new_x[s] = 8'(s * 12);
      new_y[s] = 8'(s * 10);
    end
  endtask

  initial begin
    int len, cnt, extra, budget;
    for (int s = 0; s < SLOTS; s++) begin
      cur_x[s] = '0; cur_y[s] = '0; new_x[s] = '0; new_y[s] = '0;
    end
    #1 check("reset_busy_init", busy, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // First frame after reset erases nothing: 10 setups, MOVE, 10 x (1+16), DONE.
    vis_mask = '1;
    set_grid();
    run_frame(0, 182, "A");
    check("A_white", white_cnt, 160);
    check("A_black", blk_cnt, 0);

    // Same mask again, with a stray tick in cycle 5.
    run_frame(5, 342, "B");
    check("B_black", blk_cnt, 160);
    check("B_white", white_cnt, 160);

    // Only slot 3, at (10,20): row-major 4x4 block.
    vis_mask = 10'b00_0000_1000;
    new_x[3] = 8'd10; new_y[3] = 8'd20;
    run_frame(0, 198, "C");
    check("C_count", wlog.size(), 16);
    if (wlog.size() == 16) begin
      check("C_pix0", wlog[0], 10 * 256 + 20);
      check("C_pix3", wlog[3], 13 * 256 + 20);
      check("C_pix4", wlog[4], 10 * 256 + 21);
      check("C_pix15", wlog[15], 13 * 256 + 23);
    end

    // Near the screen edge, with a tick landing on the DONE cycle.
    vis_mask = 10'b00_0000_0001;
    new_x[0] = 8'd158; new_y[0] = 8'd118;
    run_frame(54, 54, "D");
    repeat (3) @(negedge clk);
    check("D_not_queued", busy, 0);
    if (CLIP) begin
      check("D_clip_count", white_cnt, 4);
    end else begin
      check("D_count", white_cnt, 16);
      if (wlog.size() == 16) begin
        check("D_pix2", wlog[2], 160 * 256 + 118);
        check("D_pix15", wlog[15], 161 * 256 + 121);
      end
    end

    // 8-bit x wrap and 7-bit y truncation.
    new_x[0] = 8'd254; new_y[0] = 8'd126;
    run_frame(0, 54, "E");
    if (CLIP) begin
      check("E_clip_count", white_cnt, 0);
    end else begin
      check("E_count", white_cnt, 16);
      if (wlog.size() == 16) begin
        check("E_pix2", wlog[2], 0 * 256 + 126);
        check("E_pix15", wlog[15], 1 * 256 + 1);
      end
    end

    // Reset during DRAW aborts the frame immediately.
    vis_mask = '1;
    set_grid();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!(plot && colour == 3'b111) && budget < 1000);
    check("draw_reached", budget < 1000, 1);
    @(posedge clk); #2 reset_n = 1'b0;
    #1 check("rst_mid_plot", plot, 0);
    check("rst_mid_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    prev_cnt = 0;
    @(negedge clk);
    check("rst_release_busy", busy, 0);
    repeat (3) @(negedge clk);

    run_frame(0, 182, "R");
    check("R_white", white_cnt, 160);
    check("R_black", blk_cnt, 0);

    // Randomized frames: masks, positions across the full 8-bit range, stray ticks.
    for (int f = 0; f < 16; f++) begin
      vis_mask = SLOTS'($urandom);
      for (int s = 0; s < SLOTS; s++) begin
        new_x[s] = 8'($urandom_range(0, 255));
        new_y[s] = 8'($urandom_range(0, 255));
      end
      cnt   = $countones(vis_mask);
      len   = frame_len(prev_cnt, cnt);
      extra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len) : 0;
      run_frame(extra, len, "rnd");
      repeat ($urandom_range(0, 4)) @(posedge clk);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
